// File: rtl/cylon_pkg.sv
// Shared types and helpers for the parametrised cylon LED scanner.
package cylon_pkg;

  typedef enum logic [1:0] {
    MODE_CYLON  = 2'b00,
    MODE_R_TO_L = 2'b01,
    MODE_L_TO_R = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  // Step period in clk cycles: base >> shift, never below 1.
  function automatic int unsigned step_period(input int unsigned base, input int unsigned shift);
    int unsigned p;
    p = (shift >= 32'd32) ? 32'd0 : (base >> shift);
    return (p == 32'd0) ? 32'd1 : p;
  endfunction

endpackage

// File: rtl/cylon_scanner_btn_debounce.sv
// Button conditioner: 2-FF synchroniser, stability counter, and a one-cycle
// pulse on each accepted 0->1 level change.
module btn_debounce
  import cylon_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic level,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d = btn_in;
    sync2_d = sync1_q;
    level_d = level_q;
    press_d = 1'b0;
    cnt_d   = '0;
    // The count only survives while the input keeps disagreeing with the level.
    if (sync2_q != level_q) begin
      if (cnt_q >= CNT_LAST) begin
        level_d = sync2_q;
        press_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/cylon_scanner.sv
// N-LED scanner: debounced buttons pick cylon / right-to-left / left-to-right
// motion or pause, speed shifts the step period, brightness PWM-gates the LED.
module cylon_scanner
  import cylon_pkg::*;
#(
  parameter int NUM_LEDS              = 16,
  parameter int CLOCK_CYCLES_PER_STEP = 25_000_000,
  parameter int DEBOUNCE_CYCLES       = 1_000_000,
  parameter int SPEED_BITS            = 3,
  parameter int PWM_BITS              = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        btn_c,
  input  logic                        btn_l,
  input  logic                        btn_r,
  input  logic                        btn_u,
  input  logic [SPEED_BITS-1:0]       speed,
  input  logic [PWM_BITS-1:0]         brightness,
  output logic [NUM_LEDS-1:0]         led,
  output logic [$clog2(NUM_LEDS)-1:0] pos,
  output logic [1:0]                  mode,
  output logic                        paused
);

  localparam int POS_W = $clog2(NUM_LEDS);
  localparam int PRE_W = (CLOCK_CYCLES_PER_STEP > 1) ? $clog2(CLOCK_CYCLES_PER_STEP) : 1;
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(NUM_LEDS - 1);

  logic press_c, press_l, press_r, press_u;
  logic [3:0] btn_level_unused;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_c (
    .clk(clk), .reset(reset), .btn_in(btn_c), .level(btn_level_unused[0]), .press(press_c));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_l (
    .clk(clk), .reset(reset), .btn_in(btn_l), .level(btn_level_unused[1]), .press(press_l));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_r (
    .clk(clk), .reset(reset), .btn_in(btn_r), .level(btn_level_unused[2]), .press(press_r));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_u (
    .clk(clk), .reset(reset), .btn_in(btn_u), .level(btn_level_unused[3]), .press(press_u));

  mode_e               mode_q, mode_d;
  dir_e                dir_q, dir_d;
  logic [POS_W-1:0]    pos_q, pos_d;
  logic                paused_q, paused_d;
  logic [PRE_W-1:0]    pre_q, pre_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [NUM_LEDS-1:0] led_q, led_d;

  int unsigned period;
  logic        mode_sel;
  logic        tick;
  logic        lit;

  always_comb begin
    period   = step_period(32'(CLOCK_CYCLES_PER_STEP), 32'(speed));
    mode_sel = press_c | press_r | press_l;
    tick     = !paused_q && !mode_sel && (32'(pre_q) >= period - 32'd1);

    mode_d   = mode_q;
    dir_d    = dir_q;
    pos_d    = pos_q;
    pre_d    = pre_q;
    paused_d = paused_q ^ press_u;

    if (mode_sel) begin
      pre_d = '0;
      if (press_c) begin
        mode_d = MODE_CYLON;
        // Direction is only chosen on entry so a reselect keeps the sweep going.
        if (mode_q != MODE_CYLON) dir_d = (pos_q == POS_LAST) ? DIR_DOWN : DIR_UP;
      end else if (press_r) begin
        mode_d = MODE_L_TO_R;
      end else begin
        mode_d = MODE_R_TO_L;
      end
    end else if (!paused_q) begin
      if (tick) begin
        pre_d = '0;
        case (mode_q)
          MODE_R_TO_L: pos_d = (pos_q == POS_LAST) ? '0 : pos_q + 1'b1;
          MODE_L_TO_R: pos_d = (pos_q == '0) ? POS_LAST : pos_q - 1'b1;
          MODE_CYLON: begin
            if (dir_q == DIR_UP) begin
              if (pos_q == POS_LAST) begin
                dir_d = DIR_DOWN;
                pos_d = POS_LAST - 1'b1;
              end else begin
                pos_d = pos_q + 1'b1;
              end
            end else begin
              if (pos_q == '0) begin
                dir_d = DIR_UP;
                pos_d = POS_W'(1);
              end else begin
                pos_d = pos_q - 1'b1;
              end
            end
          end
          default: pos_d = pos_q;
        endcase
      end else begin
        pre_d = pre_q + 1'b1;
      end
    end

    pwm_cnt_d = pwm_cnt_q + 1'b1;
    lit       = (pwm_cnt_q < brightness) || (&brightness);
    led_d     = '0;
    if (lit) led_d[pos_q] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q    <= MODE_CYLON;
      dir_q     <= DIR_UP;
      pos_q     <= '0;
      paused_q  <= 1'b0;
      pre_q     <= '0;
      pwm_cnt_q <= '0;
      led_q     <= '0;
    end else begin
      mode_q    <= mode_d;
      dir_q     <= dir_d;
      pos_q     <= pos_d;
      paused_q  <= paused_d;
      pre_q     <= pre_d;
      pwm_cnt_q <= pwm_cnt_d;
      led_q     <= led_d;
    end
  end

  assign led    = led_q;
  assign pos    = pos_q;
  assign mode   = mode_q;
  assign paused = paused_q;

endmodule

// File: tb/tb_cylon_scanner.sv
// Directed bench for cylon_scanner with a 4-LED, short-period configuration.
module tb_cylon_scanner;

  logic       clk;
  logic       reset;
  logic       btn_c, btn_l, btn_r, btn_u;
  logic [2:0] speed;
  logic [1:0] brightness;
  logic [3:0] led;
  logic [1:0] pos;
  logic [1:0] mode;
  logic       paused;

  int errors;
  int checks;
  int seq[7] = '{0, 1, 2, 3, 2, 1, 0};
  int fast[4] = '{2, 1, 0, 3};
  int lit_n;
  int dark_n;

  cylon_scanner #(
    .NUM_LEDS(4),
    .CLOCK_CYCLES_PER_STEP(8),
    .DEBOUNCE_CYCLES(4),
    .SPEED_BITS(3),
    .PWM_BITS(2)
  ) dut (
    .clk(clk), .reset(reset),
    .btn_c(btn_c), .btn_l(btn_l), .btn_r(btn_r), .btn_u(btn_u),
    .speed(speed), .brightness(brightness),
    .led(led), .pos(pos), .mode(mode), .paused(paused)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset = 1'b1;
    btn_c = 1'b0; btn_l = 1'b0; btn_r = 1'b0; btn_u = 1'b0;
    speed = 3'd0;
    brightness = 2'd3;
    cyc(3);
    chk("rst_pos", 32'(pos), 32'd0);
    chk("rst_led", 32'(led), 32'd0);
    chk("rst_mode", 32'(mode), 32'd0);
    chk("rst_paused", 32'(paused), 32'd0);
    reset = 1'b0;

    // Idle cylon sweep: one step every 8 cycles, led trails pos by one cycle.
    for (int k = 1; k <= 48; k++) begin
      cyc(1);
      chk("idle_pos", 32'(pos), 32'(seq[k/8]));
      chk("idle_led", 32'(led), 32'd1 << seq[(k-1)/8]);
    end

    // Clean btn_l: pulse 6 edges after the press, mode follows one edge later.
    btn_l = 1'b1;
    cyc(6);
    chk("l_press", 32'(dut.u_btn_l.press), 32'd1);
    chk("l_mode_before", 32'(mode), 32'd0);
    cyc(1);
    chk("l_press_gone", 32'(dut.u_btn_l.press), 32'd0);
    chk("l_mode", 32'(mode), 32'd1);
    btn_l = 1'b0;
    cyc(7);  chk("rl_pos0", 32'(pos), 32'd0);
    cyc(1);  chk("rl_pos1", 32'(pos), 32'd1);
    cyc(16); chk("rl_pos3", 32'(pos), 32'd3);
    cyc(7);  chk("rl_pos3_hold", 32'(pos), 32'd3);
    cyc(1);  chk("rl_wrap", 32'(pos), 32'd0);

    // Three-cycle glitch must neither pulse nor restart the step period.
    btn_l = 1'b1;
    cyc(3);
    btn_l = 1'b0;
    cyc(4);
    chk("glitch_pos", 32'(pos), 32'd0);
    chk("glitch_mode", 32'(mode), 32'd1);
    cyc(1);
    chk("glitch_step", 32'(pos), 32'd1);

    // btn_c and btn_r together: centre wins.
    btn_c = 1'b1; btn_r = 1'b1;
    cyc(6); chk("cr_mode_before", 32'(mode), 32'd1);
    cyc(1); chk("cr_mode", 32'(mode), 32'd0);
    btn_c = 1'b0; btn_r = 1'b0;
    cyc(7);  chk("cr_no_step", 32'(pos), 32'd1);
    cyc(1);  chk("cr_step_up", 32'(pos), 32'd2);
    cyc(32); chk("cr_back_to_0", 32'(pos), 32'd0);
    chk("cr_mode_keep", 32'(mode), 32'd0);

    // btn_r at pos 0: left-to-right, next tick wraps to 3.
    btn_r = 1'b1;
    cyc(6); chk("r_mode_before", 32'(mode), 32'd0);
    cyc(1); chk("r_mode", 32'(mode), 32'd2);
    btn_r = 1'b0;
    cyc(7); chk("lr_pos0", 32'(pos), 32'd0);
    cyc(1); chk("lr_wrap", 32'(pos), 32'd3);

    // Pause with prescaler part-way (stops at 3), resume finishes the count.
    cyc(4); chk("u_pos_pre", 32'(pos), 32'd3);
    btn_u = 1'b1;
    cyc(6);
    chk("u_paused_before", 32'(paused), 32'd0);
    chk("u_step_before", 32'(pos), 32'd2);
    cyc(1); chk("u_paused", 32'(paused), 32'd1);
    btn_u = 1'b0;
    cyc(25);
    chk("u_frozen_a", 32'(pos), 32'd2);
    chk("u_still_paused", 32'(paused), 32'd1);
    cyc(25);
    chk("u_frozen_b", 32'(pos), 32'd2);
    btn_u = 1'b1;
    cyc(6); chk("u2_paused_before", 32'(paused), 32'd1);
    cyc(1);
    chk("u2_resumed", 32'(paused), 32'd0);
    chk("u2_pos", 32'(pos), 32'd2);
    btn_u = 1'b0;
    cyc(4); chk("u2_remaining", 32'(pos), 32'd2);
    cyc(1); chk("u2_step", 32'(pos), 32'd1);

    // speed=2: period 2.
    speed = 3'd2;
    cyc(1); chk("s2_a", 32'(pos), 32'd1);
    cyc(1); chk("s2_b", 32'(pos), 32'd0);
    cyc(1); chk("s2_c", 32'(pos), 32'd0);
    cyc(1); chk("s2_d", 32'(pos), 32'd3);

    // speed=7: period clamps to 1.
    speed = 3'd7;
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      chk("s7_step", 32'(pos), 32'(fast[i]));
    end

    // Over-range count after speed change ticks at once.
    speed = 3'd0;
    cyc(5); chk("sw_pre5", 32'(pos), 32'd3);
    speed = 3'd2;
    cyc(1); chk("sw_tick", 32'(pos), 32'd2);
    speed = 3'd0;

    // brightness=1: lit exactly one PWM slot of four.
    brightness = 2'd1;
    lit_n = 0;
    dark_n = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      if (led == 4'b0100) lit_n++;
      else if (led == 4'b0000) dark_n++;
    end
    chk("pwm1_lit", 32'(lit_n), 32'd1);
    chk("pwm1_dark", 32'(dark_n), 32'd3);

    brightness = 2'd0;
    for (int i = 0; i < 8; i++) begin
      cyc(1);
      chk("pwm0_dark", 32'(led), 32'd0);
    end
    chk("pwm0_pos", 32'(pos), 32'd1);

    // Reset mid-sweep with a button mid-debounce.
    brightness = 2'd3;
    cyc(18);
    chk("pre_rst_pos3", 32'(pos), 32'd3);
    btn_r = 1'b1;
    cyc(2);
    chk("pre_rst_pos", 32'(pos), 32'd2);
    chk("pre_rst_led", 32'(led), 32'd8);
    reset = 1'b1;
    btn_r = 1'b0;
    cyc(1);
    chk("mid_rst_pos", 32'(pos), 32'd0);
    chk("mid_rst_led", 32'(led), 32'd0);
    chk("mid_rst_mode", 32'(mode), 32'd0);
    chk("mid_rst_paused", 32'(paused), 32'd0);
    reset = 1'b0;
    cyc(1); chk("post_rst_led", 32'(led), 32'd1);
    cyc(6);
    chk("post_rst_pos", 32'(pos), 32'd0);
    chk("post_rst_mode", 32'(mode), 32'd0);
    cyc(1); chk("post_rst_step", 32'(pos), 32'd1);
    cyc(10); chk("post_rst_no_press", 32'(mode), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
